// File: rtl/rf_nr2w_pkg.sv
// rf_nr2w_pkg: default geometry for the multi-port register file.
package rf_nr2w_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_ZERO_REG = 1;
endpackage

// File: rtl/rf_nr2w_if.sv
// rf_nr2w_if: read/write port bundle of the register file.
interface rf_nr2w_if #(
  parameter int WIDTH = 32,
  parameter int AW = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic wr_en0;
  logic [AW-1:0] wr_addr0;
  logic [WIDTH-1:0] wr_data0;
  logic wr_en1;
  logic [AW-1:0] wr_addr1;
  logic [WIDTH-1:0] wr_data1;
  logic wr_collide;
  modport master(output rd_addr, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
                 input rd_data, wr_collide);
  modport slave(input rd_addr, wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1,
                output rd_data, wr_collide);
endinterface

// File: rtl/rf_nr2w_rd_port.sv
// rf_nr2w_rd_port: one combinational read mux; RF_BYPASS_EN adds write-first forwarding.
module rf_nr2w_rd_port #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic rst,
  input  logic [AW-1:0] addr,
  input  logic [DEPTH-1:0][WIDTH-1:0] mem,
`ifdef RF_BYPASS_EN
  input  logic wr_en0,
  input  logic [AW-1:0] wr_addr0,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic wr_en1,
  input  logic [AW-1:0] wr_addr1,
  input  logic [WIDTH-1:0] wr_data1,
`endif
  output logic [WIDTH-1:0] data
);
  logic [WIDTH-1:0] raw;
  always_comb begin
`ifdef RF_BYPASS_EN
    raw = (wr_en1 && wr_addr1 == addr) ? wr_data1 :
          (wr_en0 && wr_addr0 == addr) ? wr_data0 : mem[addr];
`else
    raw = mem[addr];
`endif
    data = (rst || (ZERO_REG != 0 && addr == '0)) ? '0 : raw;
  end
endmodule

// File: rtl/rf_nr2w.sv
// rf_nr2w: NUM_RD-read / 2-write register file with collision flag.
// Define RF_BYPASS_EN for write-first reads; otherwise reads return stored contents.
module rf_nr2w
  import rf_nr2w_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic clk,
  input logic rst,
  rf_nr2w_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [NUM_RD*WIDTH-1:0] rd_data;
  logic we0, we1;
  always_comb begin
    we0 = bus.wr_en0 && !(ZERO_REG != 0 && bus.wr_addr0 == '0);
    we1 = bus.wr_en1 && !(ZERO_REG != 0 && bus.wr_addr1 == '0);
  end
  // port 1 is written last so it wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
      bus.wr_collide <= 1'b0;
    end else begin
      if (we0) mem[bus.wr_addr0] <= bus.wr_data0;
      if (we1) mem[bus.wr_addr1] <= bus.wr_data1;
      bus.wr_collide <= bus.wr_en0 && bus.wr_en1 && bus.wr_addr0 == bus.wr_addr1;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_nr2w_rd_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_rd (
      .rst(rst),
      .addr(bus.rd_addr[k*AW +: AW]),
      .mem(mem),
`ifdef RF_BYPASS_EN
      .wr_en0(bus.wr_en0),
      .wr_addr0(bus.wr_addr0),
      .wr_data0(bus.wr_data0),
      .wr_en1(bus.wr_en1),
      .wr_addr1(bus.wr_addr1),
      .wr_data1(bus.wr_data1),
`endif
      .data(rd_data[k*WIDTH +: WIDTH])
    );
  end
  assign bus.rd_data = rd_data;
endmodule
